// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, DIGIT bits per clock, LSB digit first
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               request; sampled only in IDLE
//   a, b, cin, sub      operands, carry/borrow-in, mode (0 add, 1 sub); latched on accept
//   busy, done          state != IDLE; one-cycle result-valid pulse
//   s, cout, overflow   result, raw MSB carry out, signed overflow
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q;
    logic [DIGIT-1:0] a_d, b_d;
    logic [DIGIT:0]   sum;
    logic             msb_cin;
    logic             last;
    // b_q already holds the complemented operand in sub mode, so RUN is a plain add
    always_comb begin
        a_d     = a_q[cnt*DIGIT +: DIGIT];
        b_d     = b_q[cnt*DIGIT +: DIGIT];
        sum     = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
        // carry into the digit's top bit recovered from that bit's sum
        msb_cin = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ sum[DIGIT-1];
        last    = cnt == CW'(N - 1);
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            s        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_q      <= a;
                b_q      <= sub ? ~b : b;
                carry    <= cin ^ sub;
                cnt      <= '0;
                s        <= '0;
                cout     <= 1'b0;
                overflow <= 1'b0;
                state    <= RUN;
            end
        end else if (state == RUN) begin
            s[cnt*DIGIT +: DIGIT] <= sum[DIGIT-1:0];
            carry <= sum[DIGIT];
            cnt   <= cnt + 1'b1;
            if (last) begin
                cout     <= sum[DIGIT];
                overflow <= msb_cin ^ sum[DIGIT];
                state    <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule
